// File: rtl/cpu_bus_responder.sv
// Bus responder for the 6502-class core: zero-wait timer/irq register window
// plus a req/ack bridge to slow external memory that stalls the core via hold.
module cpu_bus_responder #(
   parameter logic [15:0] PERIPH_BASE = 16'hFF00,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   output logic [7:0]  cpu_in,
   output logic        cpu_hold,
   output logic        cpu_intr,
   output logic [15:0] ext_address,
   output logic [7:0]  ext_wdata,
   output logic        ext_we,
   output logic        ext_req,
   input  logic        ext_ack,
   input  logic [7:0]  ext_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [15:0] ext_address_q, ext_address_d;
   logic [7:0]  ext_wdata_q, ext_wdata_d;
   logic        ext_we_q, ext_we_d;
   logic        ext_req_q, ext_req_d;
   logic [15:0] reload_q, reload_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  shadow_q, shadow_d;
   logic        en_q, en_d;
   logic        irq_en_q, irq_en_d;
   logic        auto_q, auto_d;
   logic        pend_q, pend_d;
   logic        tmo_q, tmo_d;
   logic        intr_q, intr_d;

   logic        per;
   logic [2:0]  off;
   logic        acc, wr, rd;
   logic        pend_set, tmo_set;
   logic [7:0]  reg_rdata;

   assign per = (cpu_address[15:3] == PERIPH_BASE[15:3]);
   assign off = cpu_address[2:0];
   assign acc = (state_q == IDLE) && per;
   assign wr  = acc && cpu_we;
   assign rd  = acc && !cpu_we;

   always_comb begin
      reg_rdata = 8'h00;
      case (off)
         3'd0:    reg_rdata = reload_q[7:0];
         3'd1:    reg_rdata = reload_q[15:8];
         3'd2:    reg_rdata = {5'b0, auto_q, irq_en_q, en_q};
         3'd3:    reg_rdata = {6'b0, tmo_q, pend_q};
         3'd4:    reg_rdata = cnt_q[7:0];
         3'd5:    reg_rdata = shadow_q;
         default: reg_rdata = 8'h00;
      endcase
   end

   assign cpu_hold    = acc || (state_q == DONE);
   assign cpu_in      = (state_q == DONE) ? rdata_q :
                        (per ? reg_rdata : 8'h00);
   assign cpu_intr    = intr_q;
   assign ext_address = ext_address_q;
   assign ext_wdata   = ext_wdata_q;
   assign ext_we      = ext_we_q;
   assign ext_req     = ext_req_q;

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      rdata_d       = rdata_q;
      ext_address_d = ext_address_q;
      ext_wdata_d   = ext_wdata_q;
      ext_we_d      = ext_we_q;
      ext_req_d     = ext_req_q;
      tmo_set       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!per) begin
               ext_address_d = cpu_address;
               ext_wdata_d   = cpu_out;
               ext_we_d      = cpu_we;
               ext_req_d     = 1'b1;
               wait_cnt_d    = 8'h00;
               state_d       = WAIT;
            end
         end
         WAIT: begin
            if (ext_ack) begin
               rdata_d   = ext_rdata;
               ext_req_d = 1'b0;
               state_d   = DONE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               rdata_d   = 8'hFF;
               ext_req_d = 1'b0;
               tmo_set   = 1'b1;
               state_d   = DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Expiry reloads in the same edge, so the irq period equals RELOAD.
   always_comb begin
      cnt_d    = cnt_q;
      en_d     = en_q;
      irq_en_d = irq_en_q;
      auto_d   = auto_q;
      reload_d = reload_q;
      shadow_d = shadow_q;
      pend_set = 1'b0;
      if (en_q) begin
         if (cnt_q == 16'd1) begin
            pend_set = 1'b1;
            if (auto_q) begin
               cnt_d = reload_q;
            end else begin
               cnt_d = 16'd0;
               en_d  = 1'b0;
            end
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end
      if (wr && off == 3'd0) reload_d[7:0]  = cpu_out;
      if (wr && off == 3'd1) reload_d[15:8] = cpu_out;
      if (wr && off == 3'd2) begin
         en_d     = cpu_out[0];
         irq_en_d = cpu_out[1];
         auto_d   = cpu_out[2];
         if (cpu_out[0] && !en_q) cnt_d = reload_q;
      end
      if (rd && off == 3'd4) shadow_d = cnt_q[15:8];
      pend_d = (pend_q & ~(wr && off == 3'd3 && cpu_out[0])) | pend_set;
      tmo_d  = (tmo_q & ~(wr && off == 3'd3 && cpu_out[1])) | tmo_set;
      intr_d = pend_q & irq_en_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         wait_cnt_q    <= 8'h00;
         rdata_q       <= 8'h00;
         ext_address_q <= 16'h0000;
         ext_wdata_q   <= 8'h00;
         ext_we_q      <= 1'b0;
         ext_req_q     <= 1'b0;
         reload_q      <= 16'h0000;
         cnt_q         <= 16'h0000;
         shadow_q      <= 8'h00;
         en_q          <= 1'b0;
         irq_en_q      <= 1'b0;
         auto_q        <= 1'b0;
         pend_q        <= 1'b0;
         tmo_q         <= 1'b0;
         intr_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         rdata_q       <= rdata_d;
         ext_address_q <= ext_address_d;
         ext_wdata_q   <= ext_wdata_d;
         ext_we_q      <= ext_we_d;
         ext_req_q     <= ext_req_d;
         reload_q      <= reload_d;
         cnt_q         <= cnt_d;
         shadow_q      <= shadow_d;
         en_q          <= en_d;
         irq_en_q      <= irq_en_d;
         auto_q        <= auto_d;
         pend_q        <= pend_d;
         tmo_q         <= tmo_d;
         intr_q        <= intr_d;
      end
   end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: directed scenarios with literal expectations,
// then random core/memory traffic checked every cycle against a bus model.
module tb_cpu_bus_responder;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] cpu_address = 16'hFF07;
   logic [7:0]  cpu_out = 8'h00;
   logic        cpu_we = 1'b0;
   logic [7:0]  cpu_in;
   logic        cpu_hold;
   logic        cpu_intr;
   logic [15:0] ext_address;
   logic [7:0]  ext_wdata;
   logic        ext_we;
   logic        ext_req;
   logic        ext_ack = 1'b0;
   logic [7:0]  ext_rdata = 8'h00;

   int total = 0;
   int bad = 0;

   cpu_bus_responder #(.PERIPH_BASE(16'hFF00), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
      .cpu_in(cpu_in), .cpu_hold(cpu_hold), .cpu_intr(cpu_intr),
      .ext_address(ext_address), .ext_wdata(ext_wdata), .ext_we(ext_we),
      .ext_req(ext_req), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: transaction phase + register file as plain variables.
   bit        mvalid = 0;
   bit        m_adv = 1;
   int        m_phase = 0;   // 0 free, 1 memory busy, 2 data returned
   int        m_waited = 0;
   bit [7:0]  m_rd = 0;
   bit [15:0] m_ea = 0;
   bit [7:0]  m_ewd = 0;
   bit        m_ewe = 0, m_ereq = 0;
   bit [15:0] m_reload = 0, m_cnt = 0;
   bit        m_en = 0, m_ien = 0, m_ar = 0, m_pend = 0, m_tmo = 0, m_intr = 0;
   bit [7:0]  m_shadow = 0;

   function automatic bit is_per(input logic [15:0] a);
      return a >= 16'hFF00 && a <= 16'hFF07;
   endfunction

   function automatic bit [7:0] reg_val(input int o);
      case (o)
         0: return m_reload[7:0];
         1: return m_reload[15:8];
         2: return {5'b0, m_ar, m_ien, m_en};
         3: return {6'b0, m_tmo, m_pend};
         4: return m_cnt[7:0];
         5: return m_shadow;
         default: return 8'h00;
      endcase
   endfunction

   function automatic bit exp_hold();
      return (m_phase == 0 && is_per(cpu_address)) || m_phase == 2;
   endfunction

   always @(posedge clock) begin
      if (!reset_n) begin
         mvalid = 1; m_adv = 1;
         m_phase = 0; m_waited = 0; m_rd = 0;
         m_ea = 0; m_ewd = 0; m_ewe = 0; m_ereq = 0;
         m_reload = 0; m_cnt = 0; m_shadow = 0;
         m_en = 0; m_ien = 0; m_ar = 0; m_pend = 0; m_tmo = 0; m_intr = 0;
      end else if (mvalid) begin
         automatic bit p = is_per(cpu_address);
         automatic int o = int'(cpu_address[2:0]);
         automatic bit acc = (m_phase == 0) && p;
         automatic bit [15:0] o_cnt = m_cnt;
         automatic bit [15:0] o_rel = m_reload;
         automatic bit o_en = m_en;
         automatic bit set_p = 0, set_t = 0, clr_p = 0, clr_t = 0;
         m_adv = exp_hold();
         m_intr = m_pend & m_ien;
         case (m_phase)
            0: if (!p) begin
                  m_ea = cpu_address; m_ewd = cpu_out; m_ewe = cpu_we;
                  m_ereq = 1; m_waited = 0; m_phase = 1;
               end
            1: if (ext_ack) begin
                  m_rd = ext_rdata; m_ereq = 0; m_phase = 2;
               end else if (m_waited == TMO - 1) begin
                  m_rd = 8'hFF; m_ereq = 0; set_t = 1; m_phase = 2;
               end else m_waited++;
            default: m_phase = 0;
         endcase
         if (o_en) begin
            if (o_cnt == 1) begin
               set_p = 1;
               if (m_ar) m_cnt = o_rel;
               else begin m_cnt = 0; m_en = 0; end
            end else m_cnt = o_cnt - 16'd1;
         end
         if (acc && cpu_we) begin
            case (o)
               0: m_reload[7:0] = cpu_out;
               1: m_reload[15:8] = cpu_out;
               2: begin
                  m_en = cpu_out[0]; m_ien = cpu_out[1]; m_ar = cpu_out[2];
                  if (cpu_out[0] && !o_en) m_cnt = o_rel;
               end
               3: begin clr_p = cpu_out[0]; clr_t = cpu_out[1]; end
               default: ;
            endcase
         end
         if (acc && !cpu_we && o == 4) m_shadow = o_cnt[15:8];
         m_pend = (m_pend & !clr_p) | set_p;
         m_tmo = (m_tmo & !clr_t) | set_t;
      end
   end

   always @(negedge clock) begin
      if (mvalid) begin
         automatic bit h = exp_hold();
         chk("hold", {15'b0, cpu_hold}, {15'b0, h});
         if (h)
            chk("cpu_in", {8'h00, cpu_in},
                {8'h00, (m_phase == 2) ? m_rd : reg_val(int'(cpu_address[2:0]))});
         chk("intr", {15'b0, cpu_intr}, {15'b0, m_intr});
         chk("ext_req", {15'b0, ext_req}, {15'b0, m_ereq});
         chk("ext_we", {15'b0, ext_we}, {15'b0, m_ewe});
         chk("ext_address", ext_address, m_ea);
         chk("ext_wdata", {8'h00, ext_wdata}, {8'h00, m_ewd});
      end
   end

   task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d,
                      input logic ack, input logic [7:0] rdat, input logic rn);
      @(posedge clock);
      #1;
      cpu_address = a; cpu_we = w; cpu_out = d;
      ext_ack = ack; ext_rdata = rdat; reset_n = rn;
      @(negedge clock);
   endtask

   task automatic per_rd(input logic [15:0] a, input string name,
                         input logic [7:0] exp);
      cyc(a, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk(name, {8'h00, cpu_in}, {8'h00, exp});
   endtask

   task automatic per_wr(input logic [15:0] a, input logic [7:0] d);
      cyc(a, 1'b1, d, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      int n;
      logic [15:0] a;
      logic        w;
      logic [7:0]  d;
      cyc(16'hFF07, 0, 0, 0, 0, 0);
      cyc(16'hFF07, 0, 0, 0, 0, 0);
      chk("rst_req", {15'b0, ext_req}, 16'h0000);
      chk("rst_intr", {15'b0, cpu_intr}, 16'h0000);
      chk("rst_addr", ext_address, 16'h0000);

      // read $1234, ack in second WAIT cycle
      cyc(16'h1234, 0, 0, 0, 0, 1);
      chk("rd_idle_hold", {15'b0, cpu_hold}, 16'h0000);
      cyc(16'h1234, 0, 0, 0, 0, 1);
      chk("rd_w1_hold", {15'b0, cpu_hold}, 16'h0000);
      chk("rd_addr", ext_address, 16'h1234);
      chk("rd_we", {15'b0, ext_we}, 16'h0000);
      chk("rd_req", {15'b0, ext_req}, 16'h0001);
      cyc(16'h1234, 0, 0, 1, 8'h5A, 1);
      chk("rd_w2_hold", {15'b0, cpu_hold}, 16'h0000);
      cyc(16'h1234, 0, 0, 0, 0, 1);
      chk("rd_done_hold", {15'b0, cpu_hold}, 16'h0001);
      chk("rd_done_data", {8'h00, cpu_in}, 16'h005A);

      // write $A5 to $0200, immediate ack
      cyc(16'h0200, 1, 8'hA5, 0, 0, 1);
      cyc(16'h0200, 1, 8'hA5, 1, 8'h33, 1);
      chk("wr_we", {15'b0, ext_we}, 16'h0001);
      chk("wr_data", {8'h00, ext_wdata}, 16'h00A5);
      chk("wr_req", {15'b0, ext_req}, 16'h0001);
      cyc(16'h0200, 1, 8'hA5, 0, 0, 1);
      chk("wr_done_hold", {15'b0, cpu_hold}, 16'h0001);
      chk("wr_req_drop", {15'b0, ext_req}, 16'h0000);

      // timeout: stall 1+TMO cycles, $FF returned, bus_timeout sticky
      n = 0;
      cyc(16'h0300, 0, 0, 0, 0, 1);
      while (!cpu_hold && n < 20) begin
         n++;
         cyc(16'h0300, 0, 0, 0, 0, 1);
      end
      chk("tmo_stall", 16'(n), 16'(1 + TMO));
      chk("tmo_data", {8'h00, cpu_in}, 16'h00FF);
      per_rd(16'hFF03, "tmo_status", 8'h02);
      per_wr(16'hFF03, 8'h02);
      per_rd(16'hFF03, "tmo_clear", 8'h00);

      // timer with autoreload and irq
      per_wr(16'hFF00, 8'h03);
      per_wr(16'hFF01, 8'h00);
      per_wr(16'hFF02, 8'h07);
      per_rd(16'hFF03, "tm_k1", 8'h00);
      per_rd(16'hFF03, "tm_k2", 8'h00);
      per_rd(16'hFF03, "tm_k3", 8'h00);
      per_rd(16'hFF03, "tm_pend", 8'h01);
      chk("tm_intr_lag", {15'b0, cpu_intr}, 16'h0000);
      per_rd(16'hFF04, "tm_reload", 8'h02);
      chk("tm_intr", {15'b0, cpu_intr}, 16'h0001);
      per_wr(16'hFF03, 8'h01);
      per_rd(16'hFF03, "tm_setwins", 8'h01);
      per_wr(16'hFF02, 8'h00);
      per_wr(16'hFF03, 8'h01);

      // CNT_HI reads the shadow latched by the CNT_LO read
      per_wr(16'hFF00, 8'h00);
      per_wr(16'hFF01, 8'h01);
      per_wr(16'hFF02, 8'h01);
      per_rd(16'hFF04, "sh_lo", 8'h00);
      per_rd(16'hFF07, "sh_gap", 8'h00);
      per_rd(16'hFF05, "sh_hi", 8'h01);
      per_wr(16'hFF02, 8'h00);

      // reset during WAIT, late ack ignored
      cyc(16'h0400, 0, 0, 0, 0, 1);
      cyc(16'h0400, 0, 0, 0, 0, 1);
      chk("rw_req", {15'b0, ext_req}, 16'h0001);
      cyc(16'h0400, 0, 0, 0, 0, 0);
      cyc(16'hFF01, 0, 0, 1, 8'h77, 1);
      chk("rw_req_drop", {15'b0, ext_req}, 16'h0000);
      chk("rw_reload", {8'h00, cpu_in}, 16'h0000);
      cyc(16'hFF07, 0, 0, 0, 0, 1);
      chk("rw_no_done", {8'h00, cpu_in}, 16'h0000);

      // random traffic against the model
      a = 16'hFF07; w = 0; d = 0;
      for (int i = 0; i < 4000; i++) begin
         automatic int r = int'($urandom_range(0, 9));
         automatic logic rn = ($urandom_range(0, 399) != 0);
         if (m_adv || !reset_n) begin
            if (r < 5) a = 16'hFF00 + 16'($urandom_range(0, 7));
            else if (r == 5) begin
               case ($urandom_range(0, 4))
                  0: a = 16'hFEF8;
                  1: a = 16'hFEFF;
                  2: a = 16'hFF08;
                  3: a = 16'hFFFA;
                  default: a = 16'hFFFF;
               endcase
            end else a = 16'($urandom);
            w = $urandom_range(0, 1) == 1;
            if (a[2:0] == 3'd1 && is_per(a))
               d = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
            else if (a[2:0] == 3'd0 && is_per(a))
               d = 8'($urandom_range(0, 12));
            else d = 8'($urandom);
         end
         cyc(a, w, d, $urandom_range(0, 3) == 0, 8'($urandom), rn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Bus responder for the 6502-class core: decodes every core access (address/out/we), serves an on-chip 16-bit timer/interrupt register window with zero wait states, and forwards all other addresses to a slow external memory over a req/ack handshake, stalling the core via its `hold` input until data returns. It sits between the core and the board memory, and also drives the core's `intr`.

## Interface
- PERIPH_BASE, 16'hFF00, base of 8-byte register window (bits [2:0] ignored)
- TIMEOUT, 255, max WAIT cycles before an external access is aborted (1..255)
- clock  in  1  system clock; all state on posedge
- reset_n  in  1  synchronous, active-low reset
- cpu_address  in  16  core address
- cpu_out  in  8  core write data
- cpu_we  in  1  core write strobe; every cycle with cpu_we=1 is one write
- cpu_in  out  8  read data to core (combinational)
- cpu_hold  out  1  1 = core may advance this cycle (combinational)
- cpu_intr  out  1  interrupt request = irq_pending & irq_en (registered)
- ext_address  out  16  external address (registered)
- ext_wdata  out  8  external write data (registered)
- ext_we  out  1  external write (registered)
- ext_req  out  1  external request, held until ack or timeout
- ext_ack  in  1  external completion, one-cycle pulse
- ext_rdata  in  8  external read data, valid with ext_ack

## Operation
- Decode: per = (cpu_address[15:3] == PERIPH_BASE[15:3]); all other addresses external, including $FFFA-$FFFF vectors.
- Access completes on a posedge where cpu_hold=1; the core keeps address/we/out stable while cpu_hold=0.
- Peripheral access: cpu_hold=1; reads return register mux; writes commit at that posedge.
- Registers (offset): 0 RELOAD_LO, 1 RELOAD_HI (R/W); 2 CTRL R/W (bit0 enable, bit1 irq_en, bit2 autoreload, others read 0); 3 STATUS (bit0 irq_pending, bit1 bus_timeout; write 1 clears, sticky); 4 CNT_LO read (latches CNT[15:8] into shadow); 5 CNT_HI read returns shadow; 6,7 read $00, writes ignored. Writes to 4/5 ignored.
- Timer: each clock with enable=1, CNT decrements by 1 (wraps $0000→$FFFF only if it was already 0 when enabled). Decrement 1→0 sets irq_pending; then CNT<=RELOAD if autoreload else enable<=0.
- Writing CTRL with enable going 0→1 loads CNT<=RELOAD that cycle (no decrement). RELOAD writes while running affect only the next reload.
- Simultaneous STATUS W1C and new set of the same bit: set wins.
- External FSM states IDLE, WAIT, DONE:
  - IDLE: per=0 → cpu_hold=0; latch ext_address/ext_wdata/ext_we from core, ext_req<=1, cnt<=0, →WAIT. per=1 → cpu_hold=1, stay.
  - WAIT: cpu_hold=0. ext_ack → rdata_q<=ext_rdata, ext_req<=0, →DONE. Else cnt==TIMEOUT-1 → rdata_q<=$FF, ext_req<=0, bus_timeout<=1, →DONE. Else cnt++.
  - DONE: cpu_hold=1, cpu_in=rdata_q (writes: cpu_in=rdata_q, ignored by core); →IDLE.
- ext_ack outside WAIT is ignored.
- Reset: FSM IDLE, ext_req/ext_we 0, ext_address/ext_wdata $0000/$00, rdata_q $00, all registers and shadow $00, cpu_intr 0. Reset mid-WAIT drops ext_req the next posedge; a late ack is ignored.

## Timing
- Peripheral read/write: 1 cycle, cpu_hold=1 throughout.
- External access with ack in first WAIT cycle: 3 cycles (IDLE stall, WAIT stall, DONE complete); each extra WAIT cycle adds 1.
- Timeout: core stalled 1+TIMEOUT cycles, completes in DONE with $FF.
- Back-to-back external accesses: DONE→IDLE then new request; no overlap, ext_req low at least 2 cycles between requests.
- cpu_intr rises the cycle after irq_pending sets (core samples edges); falls the cycle after W1C or irq_en clear.
- cpu_in combinational from state, address, registers; cpu_hold combinational from state and decode.

## Test plan
- Reset, read $1234 with ack after 2 WAIT cycles, ext_rdata=$5A → cpu_hold low 3 cycles, ext_address=$1234, ext_we=0, DONE cycle cpu_in=$5A, hold=1.
- Write $A5 to $0200, ack immediate → ext_we=1, ext_wdata=$A5, access completes in 3 cycles, ext_req 1 for exactly 1 cycle.
- No ack, TIMEOUT=4 → hold low 5 cycles, cpu_in=$FF, STATUS reads $02; write $02 to $FF03 → STATUS $00.
- RELOAD=$0003, CTRL=$07 → irq_pending set 3 cycles after enable, cpu_intr=1 next cycle, CNT reloads $0003; W1C in same cycle as next expiry → pending stays 1.
- CNT=$0100 then read $FF04 at $0100 and $FF05 two cycles later → returns $00 then $01 (shadow), not live $00.
- Assert reset_n=0 during WAIT, pulse ext_ack after → ext_req 0, FSM IDLE, no DONE, registers $00.
